// File: rtl/split_comp_pkg.sv
// Shared definitions for the split-compensation datapath (address generator, line fetch,
// compensated-frame writer).
//   state_e             line fetch FSM encoding
//   LINE_BYTES          bytes per 1024-pixel line
//   BYTES_PER_PIX       bytes per 32-bit pixel
//   BLACK_PIXEL_DEFAULT fill value for rows shifted outside the source frame
package split_comp_pkg;

  localparam int unsigned BYTES_PER_PIX = 4;
  localparam int unsigned LINE_BYTES    = 4096;

  localparam logic [31:0] BLACK_PIXEL_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StReq,
    StWaitData,
    StBlank,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/line_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO for the line fetch output path.
//   clk, rst_n   clock, asynchronous active-low reset (flushes contents)
//   push, wdata  write strobe and data; ignored when full
//   pop          read strobe; ignored when empty
//   rdata        head entry, valid whenever empty is low
//   full, empty  status flags
//   free         number of unused entries
// DEPTH must be a power of two so the pointers wrap naturally.
module line_fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign free    = CNT_W'(DEPTH) - count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

endmodule

// File: rtl/v_line_fetch.sv
// Vertical line fetch: on each address-generator done pulse, burst-reads one source line from
// the frame buffer (or synthesises a black line when the source row lies outside the frame) and
// streams it out as 32-bit pixels with valid/ready.
//   i_clk, i_rst_n                         clock, asynchronous active-low reset
//   i_y_done, i_new_addr                   line start pulse and source line byte address
//   i_frame_base_addr                      source frame base byte address
//   o_rd_req, o_rd_addr, i_rd_ack          burst read request handshake
//   i_rd_data, i_rd_data_valid             read beats (cannot be stalled)
//   o_pix_data/valid/last, i_pix_ready     output pixel stream
//   o_busy, o_line_done, o_overrun         status
module v_line_fetch
  import split_comp_pkg::*;
#(
  parameter int unsigned LINE_PIXELS = 1024,
  parameter int unsigned FRAME_LINES = 768,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FIFO_DEPTH  = 32,
  parameter logic [31:0] BLACK_PIXEL = BLACK_PIXEL_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_y_done,
  input  logic [31:0] i_new_addr,
  input  logic [31:0] i_frame_base_addr,
  output logic        o_rd_req,
  output logic [31:0] o_rd_addr,
  input  logic        i_rd_ack,
  input  logic [31:0] i_rd_data,
  input  logic        i_rd_data_valid,
  output logic [31:0] o_pix_data,
  output logic        o_pix_valid,
  output logic        o_pix_last,
  input  logic        i_pix_ready,
  output logic        o_busy,
  output logic        o_line_done,
  output logic        o_overrun
);

  localparam int unsigned WORD_W = $clog2(LINE_PIXELS) + 1;
  localparam int unsigned OUT_W  = $clog2(LINE_PIXELS);
  localparam int unsigned BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int unsigned FREE_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] FRAME_BYTES = 32'(FRAME_LINES * LINE_BYTES);

  state_e             state_q, state_d;
  logic [31:0]        src_addr_q, src_addr_d;
  logic [WORD_W-1:0]  words_req_q, words_req_d;
  logic [WORD_W-1:0]  blank_cnt_q, blank_cnt_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [OUT_W-1:0]   out_cnt_q;
  logic               overrun_q, overrun_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]        fifo_wdata, fifo_rdata;
  logic [FREE_W-1:0]  fifo_free;
  logic [31:0]        src_offset;
  logic               in_range;

  // Subtraction wraps for addresses below the base, so one unsigned compare rejects both sides.
  assign src_offset = src_addr_q - i_frame_base_addr;
  assign in_range   = (src_offset < FRAME_BYTES) && (src_addr_q[1:0] == 2'b00);

  assign o_busy      = (state_q != StIdle) && (state_q != StDone);
  assign o_line_done = (state_q == StDone);
  assign o_overrun   = overrun_q;
  assign o_rd_addr   = src_addr_q + {{(32-WORD_W-2){1'b0}}, words_req_q, 2'b00};

  assign fifo_pop    = ~fifo_empty & i_pix_ready;
  assign o_pix_valid = ~fifo_empty;
  assign o_pix_data  = fifo_empty ? 32'h0 : fifo_rdata;
  assign o_pix_last  = ~fifo_empty && (out_cnt_q == OUT_W'(LINE_PIXELS - 1));

  always_comb begin
    state_d     = state_q;
    src_addr_d  = src_addr_q;
    words_req_d = words_req_q;
    blank_cnt_d = blank_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    overrun_d   = overrun_q | (i_y_done & o_busy);
    fifo_push   = 1'b0;
    fifo_wdata  = i_rd_data;
    o_rd_req    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (i_y_done) begin
          src_addr_d  = i_new_addr;
          words_req_d = '0;
          blank_cnt_d = '0;
          beat_cnt_d  = '0;
          state_d     = StCheck;
        end
      end
      StCheck: state_d = in_range ? StReq : StBlank;
      StReq: begin
        // Nothing pushes in this state, so free space only grows while the request is held.
        o_rd_req = (fifo_free >= FREE_W'(BURST_LEN));
        if (o_rd_req && i_rd_ack) state_d = StWaitData;
      end
      StWaitData: begin
        if (i_rd_data_valid) begin
          fifo_push = 1'b1;
          if (beat_cnt_q == BEAT_W'(BURST_LEN - 1)) begin
            beat_cnt_d  = '0;
            words_req_d = words_req_q + WORD_W'(BURST_LEN);
            state_d     = (words_req_d == WORD_W'(LINE_PIXELS)) ? StDrain : StReq;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      StBlank: begin
        if (!fifo_full) begin
          fifo_push   = 1'b1;
          fifo_wdata  = BLACK_PIXEL;
          blank_cnt_d = blank_cnt_q + 1'b1;
          if (blank_cnt_q == WORD_W'(LINE_PIXELS - 1)) state_d = StDrain;
        end
      end
      StDrain: if (fifo_empty) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      src_addr_q  <= '0;
      words_req_q <= '0;
      blank_cnt_q <= '0;
      beat_cnt_q  <= '0;
      out_cnt_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_addr_q  <= src_addr_d;
      words_req_q <= words_req_d;
      blank_cnt_q <= blank_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      overrun_q   <= overrun_d;
      if (fifo_pop) out_cnt_q <= out_cnt_q + 1'b1;
    end
  end

  line_fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

endmodule

// File: tb/tb_v_line_fetch.sv
module tb_v_line_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        y_done;
  logic [31:0] new_addr, base;
  logic        rd_req, rd_ack, rd_dv;
  logic [31:0] rd_addr, rd_data;
  logic [31:0] pix_data;
  logic        pix_valid, pix_last, pix_ready;
  logic        busy, line_done, overrun;

  int passed = 0;
  int total  = 0;

  logic [31:0] pix_q[$];
  int          last_q[$];
  logic [31:0] req_q[$];
  int          done_cnt, beats_sent, pops, viol, req_drop;
  bit          ready_mode;

  always #5 clk = ~clk;

  v_line_fetch dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_y_done          (y_done),
    .i_new_addr        (new_addr),
    .i_frame_base_addr (base),
    .o_rd_req          (rd_req),
    .o_rd_addr         (rd_addr),
    .i_rd_ack          (rd_ack),
    .i_rd_data         (rd_data),
    .i_rd_data_valid   (rd_dv),
    .o_pix_data        (pix_data),
    .o_pix_valid       (pix_valid),
    .o_pix_last        (pix_last),
    .i_pix_ready       (pix_ready),
    .o_busy            (busy),
    .o_line_done       (line_done),
    .o_overrun         (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Downstream ready: always 1, or one cycle in four.
  initial begin
    int rcnt = 0;
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rcnt++;
      pix_ready = ready_mode ? (rcnt % 4 == 0) : 1'b1;
    end
  end

  // Frame buffer model: ack two cycles after a request, then 16 beats of data = byte address.
  initial begin
    logic [31:0] a;
    rd_ack = 1'b0;
    rd_dv = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n && rd_req) begin
        a = rd_addr;
        req_q.push_back(a);
        repeat (2) begin
          @(negedge clk);
          if (!rd_req || rd_addr !== a) req_drop++;
        end
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
          rd_dv = 1'b1;
          rd_data = a + 32'(4 * i);
          beats_sent++;
          @(negedge clk);
        end
        rd_dv = 1'b0;
      end
    end
  end

  // Output sink and occupancy tracking (beats delivered minus pixels taken).
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_req && (32 - (beats_sent - pops) < 16)) viol++;
        if (beats_sent - pops > 32) viol++;
        if (pix_valid && pix_ready) begin
          if (pix_last) last_q.push_back(pix_q.size());
          pix_q.push_back(pix_data);
          pops++;
        end
        if (line_done) done_cnt++;
      end
    end
  end

  task automatic clear_logs();
    pix_q.delete();
    last_q.delete();
    req_q.delete();
    done_cnt = 0;
    beats_sent = 0;
    pops = 0;
    viol = 0;
    req_drop = 0;
  endtask

  task automatic start_line(input logic [31:0] a);
    @(negedge clk);
    new_addr = a;
    y_done = 1'b1;
    @(negedge clk);
    y_done = 1'b0;
  endtask

  task automatic wait_line(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n >= 20000), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_line(input string tag, input logic [31:0] src, input bit fetched);
    int derr = 0;
    int aerr = 0;
    logic [31:0] exp;
    for (int k = 0; k < pix_q.size(); k++) begin
      exp = fetched ? src + 32'(4 * k) : 32'h0;
      if (pix_q[k] !== exp) derr++;
    end
    for (int k = 0; k < req_q.size(); k++)
      if (req_q[k] !== src + 32'(64 * k)) aerr++;
    chk({tag, "_pix_count"}, pix_q.size(), 1024);
    chk({tag, "_pix_data_errors"}, derr, 0);
    chk({tag, "_last_count"}, last_q.size(), 1);
    chk({tag, "_last_index"}, (last_q.size() > 0) ? last_q[0] : -1, 1023);
    chk({tag, "_req_count"}, req_q.size(), fetched ? 64 : 0);
    chk({tag, "_req_addr_errors"}, aerr, 0);
    chk({tag, "_req_unstable"}, req_drop, 0);
    chk({tag, "_fifo_violations"}, viol, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    y_done = 1'b0;
    new_addr = '0;
    base = 32'h3FFE_A000;
    ready_mode = 1'b0;
    clear_logs();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_req", rd_req, 1'b0);
    chk("rst_rd_addr", rd_addr, 32'h0);
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_pix_data", pix_data, 32'h0);
    chk("rst_line_done", line_done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: in-frame line, request latency and burst stepping
    a = base + 32'h1000;
    start_line(a);
    chk("t1_busy_next", busy, 1'b1);
    chk("t1_req_lat1", rd_req, 1'b0);
    @(negedge clk);
    chk("t1_req_lat2", rd_req, 1'b1);
    chk("t1_first_addr", rd_addr, a);
    wait_line("t1");
    check_line("t1", a, 1'b1);

    // 2: row above the frame -> black line, first pixel 3 cycles after i_y_done
    clear_logs();
    a = base - 32'h1000;
    start_line(a);
    chk("t2_busy_next", busy, 1'b1);
    @(negedge clk);
    chk("t2_valid_lat2", pix_valid, 1'b0);
    @(negedge clk);
    chk("t2_valid_lat3", pix_valid, 1'b1);
    wait_line("t2");
    check_line("t2", a, 1'b0);

    // 3: first row past the frame is blank, last row inside is fetched
    clear_logs();
    a = base + 32'(768 * 32'h1000);
    start_line(a);
    wait_line("t3a");
    check_line("t3a", a, 1'b0);
    clear_logs();
    a = base + 32'(767 * 32'h1000);
    start_line(a);
    wait_line("t3b");
    check_line("t3b", a, 1'b1);

    // 4: slow consumer
    clear_logs();
    ready_mode = 1'b1;
    a = base + 32'h5000;
    start_line(a);
    wait_line("t4");
    check_line("t4", a, 1'b1);
    ready_mode = 1'b0;
    repeat (2) @(negedge clk);

    // 5: second i_y_done mid-burst is dropped and flags overrun
    clear_logs();
    a = base + 32'h9000;
    start_line(a);
    repeat (6) @(negedge clk);
    chk("t5_overrun_before", overrun, 1'b0);
    start_line(base + 32'h2_0000);
    chk("t5_overrun_set", overrun, 1'b1);
    wait_line("t5");
    check_line("t5", a, 1'b1);
    chk("t5_overrun_sticky", overrun, 1'b1);

    // 6: reset mid-burst, trailing beats ignored, next line intact
    clear_logs();
    a = base + 32'h3000;
    start_line(a);
    for (int n = 0; n < 200 && beats_sent < 11; n++) @(negedge clk);
    chk("t6_reached_burst", 32'(beats_sent >= 11), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_pix_valid", pix_valid, 1'b0);
    chk("t6_rst_overrun", overrun, 1'b0);
    chk("t6_rst_rd_req", rd_req, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_idle_pix_valid", pix_valid, 1'b0);
    chk("t6_idle_busy", busy, 1'b0);
    clear_logs();
    a = base + 32'h2000;
    start_line(a);
    wait_line("t6");
    check_line("t6", a, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
